dma_axi_mem_slave: RTL and testbench

- AXI4 slave memory responder: the responder end of the DMA's AXI master interface.
- Serves the DMA's read and write bursts from an internal word-addressed SRAM array.
- Returns OKAY or SLVERR per beat and per burst, so the DMA's read-error and write-error paths can be exercised.
- Used as the on-chip scratchpad target in the SoC and as the memory model in DMA benches.

---
 rtl/dma_axi_mem_slave.sv | 270 +++++++++++++++++++++++++++
 tb/tb_dma_axi_mem_slave.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_axi_mem_slave.sv
// AXI4 slave memory responder: independent read/write burst FSMs over a word-addressed
// SRAM, answering SLVERR for out-of-range, oversized or unsupported-burst beats.
module dma_axi_mem_slave #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ID_WIDTH   = 8,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, BURST_INCR = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    beat_err = (addr < BASE_ADDR) || ((off >> OFF_W) >= ADDR_WIDTH'(MEM_DEPTH)) ||
               (size > 3'(OFF_W)) || (burst > BURST_INCR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    word_idx = IDX_W'((addr - BASE_ADDR) >> OFF_W);
  endfunction

  // INCR steps from the size-aligned address, so an unaligned first beat realigns on beat 1.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] bytes;
    bytes = ADDR_WIDTH'(1) << size;
    if (burst == BURST_INCR) next_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
    else                     next_addr = addr;
  endfunction

  w_state_t              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   wid_q, wid_d, bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d, bresp_q, bresp_d;
  logic                  werr_q, werr_d, awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  w_beat_err, mem_we;

  always_comb begin
    w_state_d = w_state_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    w_beat_err = beat_err(waddr_q, wsize_q, wburst_q) || (wlast != (wcnt_q == wlen_q));
    case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        wid_d     = awid;
        waddr_d   = awaddr;
        wlen_d    = awlen;
        wsize_d   = awsize;
        wburst_d  = awburst;
        wcnt_d    = 8'd0;
        werr_d    = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (wvalid && wready_q) begin
        mem_we  = !w_beat_err;
        werr_d  = werr_q || w_beat_err;
        waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
        wcnt_d  = wcnt_q + 8'd1;
        if (wcnt_q == wlen_q) begin
          bid_d     = wid_q;
          bresp_d   = (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Memory array is never reset; byte lanes follow wstrb exactly.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx(waddr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, ld_addr;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d, ld_size;
  logic [1:0]            rburst_q, rburst_d, rresp_q, rresp_d, ld_burst;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d, ld_en, ld_err;

  // raddr_q holds the address of the next beat to load, not the one on the bus.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rvalid_d  = rvalid_q;
    ld_en     = 1'b0;
    ld_addr   = raddr_q;
    ld_size   = rsize_q;
    ld_burst  = rburst_q;
    case (r_state_q)
      R_IDLE: if (arvalid && arready_q) begin
        rid_d     = arid;
        rlen_d    = arlen;
        rsize_d   = arsize;
        rburst_d  = arburst;
        rcnt_d    = 8'd0;
        ld_en     = 1'b1;
        ld_addr   = araddr;
        ld_size   = arsize;
        ld_burst  = arburst;
        rlast_d   = (arlen == 8'd0);
        rvalid_d  = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: if (rready) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          ld_en   = 1'b1;
          rcnt_d  = rcnt_q + 8'd1;
          rlast_d = (rcnt_q + 8'd1 == rlen_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ld_err = beat_err(ld_addr, ld_size, ld_burst);
    if (ld_en) begin
      raddr_d = next_addr(ld_addr, ld_size, ld_burst);
      rdata_d = ld_err ? '0 : mem[word_idx(ld_addr)];
      rresp_d = ld_err ? RESP_SLVERR : RESP_OKAY;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
      arready_q <= arready_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
endmodule

// File: tb/tb_dma_axi_mem_slave.sv
// Directed bench for dma_axi_mem_slave: bursts, narrow writes, range errors,
// read back-pressure, protocol errors, concurrency and mid-burst reset.
module tb_dma_axi_mem_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0, rst = 1'b1;
  logic [7:0]  awid = '0, arid = '0, awlen = '0, arlen = '0, wstrb = '0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [63:0] wdata = '0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic [63:0] rdata;

  int checks = 0, errors = 0;
  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [7:0]  ridb [16];

  dma_axi_mem_slave dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                          input int last_at, output logic [1:0] resp, output logic [7:0] bid_o,
                          output int lat, output bit to);
    int n;
    to = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1;
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wbuf[b]; wstrb = strb; wvalid = 1'b1;
      wlast = (last_at < 0) ? (b == int'(len)) : (b == last_at);
      n = 0;
      while (!wready && n < 50) begin tick(); n++; end
      if (n >= 50) to = 1;
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    if (lat >= 50) to = 1;
    resp = bresp; bid_o = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit toggle,
                         output int cycles, output int stall_bad, output bit first_v,
                         output bit post_ar, output bit post_rv, output bit to);
    int n, beat;
    bit stalled;
    logic [63:0] hd;
    logic [1:0] hr;
    logic hl;
    to = 0; hd = '0; hr = '0; hl = 1'b0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    if (n >= 50) to = 1;
    tick();
    arvalid = 1'b0;
    first_v = rvalid;
    beat = 0; cycles = 0; stall_bad = 0; stalled = 0;
    while (beat <= int'(len) && cycles < 200) begin
      rready = toggle ? cycles[0] : 1'b1;
      if (stalled && (rdata !== hd || rresp !== hr || rlast !== hl)) stall_bad++;
      if (rvalid && rready) begin
        if (beat < 16) begin
          rbuf[beat] = rdata; rrsp[beat] = rresp; rlst[beat] = rlast; ridb[beat] = rid;
        end
        beat++;
        stalled = 0;
      end else begin
        stalled = rvalid; hd = rdata; hr = rresp; hl = rlast;
      end
      tick();
      cycles++;
    end
    if (cycles >= 200) to = 1;
    rready = 1'b0;
    post_ar = arready;
    post_rv = rvalid;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake: got %b, want 000000", {awready, wready, bvalid, arready, rvalid, rlast});
    end
    checks++;
    if ({bid, bresp} !== 10'h0) begin errors++; $display("FAIL reset_b: got %h, want 0", {bid, bresp}); end
    checks++;
    if ({rid, rresp} !== 10'h0) begin errors++; $display("FAIL reset_r: got %h, want 0", {rid, rresp}); end
    checks++;
    if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h, want 0", rdata); end
    rst = 1'b0;
    tick();
    checks++;
    if ({awready, arready} !== 2'b11) begin
      errors++; $display("FAIL idle_ready: got %b, want 11", {awready, arready});
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp; logic [7:0] b_id; int lat, cyc, sb; bit to, fv, pa, pv;
    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    do_write(8'h01, BASE, 8'd3, 3'd3, INCR, 8'hFF, -1, resp, b_id, lat, to);
    checks++;
    if (to || resp !== OKAY || b_id !== 8'h01 || lat !== 0) begin
      errors++; $display("FAIL incr_write: to=%0d bresp=%b bid=%h lat=%0d, want 0 00 01 0", to, resp, b_id, lat);
    end
    do_read(8'h02, BASE, 8'd3, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to);
    checks++;
    if (to || !fv || cyc !== 4) begin
      errors++; $display("FAIL incr_read_timing: to=%0d first_rvalid=%0d cycles=%0d, want 0 1 4", to, fv, cyc);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rbuf[b] !== wbuf[b] || rrsp[b] !== OKAY || rlst[b] !== (b == 3) || ridb[b] !== 8'h02) begin
        errors++; $display("FAIL incr_beat%0d: data=%h resp=%b last=%b id=%h, want %h 00 %0d 02",
                           b, rbuf[b], rrsp[b], rlst[b], ridb[b], wbuf[b], (b == 3));
      end
    end
    checks++;
    if (pa !== 1'b1 || pv !== 1'b0) begin
      errors++; $display("FAIL incr_read_end: arready=%0d rvalid=%0d, want 1 0", pa, pv);
    end
  endtask

  task automatic test_narrow();
    logic [1:0] resp; logic [7:0] b_id; int lat, cyc, sb; bit to, fv, pa, pv;
    wbuf[0] = 64'h0000_AB00_0000_0000;
    do_write(8'h03, BASE + 32'd5, 8'd0, 3'd0, INCR, 8'h20, -1, resp, b_id, lat, to);
    checks++;
    if (to || resp !== OKAY) begin errors++; $display("FAIL narrow_write: to=%0d bresp=%b, want 0 00", to, resp); end
    do_read(8'h04, BASE, 8'd1, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to);
    checks++;
    if (to || rbuf[0] !== 64'h0000_AB00_0000_0011 || rrsp[0] !== OKAY) begin
      errors++; $display("FAIL narrow_word0: to=%0d data=%h resp=%b, want 0000ab0000000011 00", to, rbuf[0], rrsp[0]);
    end
    checks++;
    if (rbuf[1] !== 64'h22) begin errors++; $display("FAIL narrow_word1: got %h, want 22", rbuf[1]); end
  endtask

  task automatic test_top_of_mem();
    logic [1:0] resp; logic [7:0] b_id; int lat, cyc, sb; bit to, fv, pa, pv;
    logic [63:0] exp_d [4];
    logic [1:0]  exp_r [4];
    for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
    exp_d[0] = 64'hA0; exp_d[1] = 64'hA1; exp_d[2] = 64'h0; exp_d[3] = 64'h0;
    exp_r[0] = OKAY; exp_r[1] = OKAY; exp_r[2] = SLVERR; exp_r[3] = SLVERR;
    do_write(8'h05, BASE + 32'd8176, 8'd3, 3'd3, INCR, 8'hFF, -1, resp, b_id, lat, to);
    checks++;
    if (to || resp !== SLVERR) begin errors++; $display("FAIL top_write: to=%0d bresp=%b, want 0 10", to, resp); end
    do_read(8'h06, BASE + 32'd8176, 8'd3, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (to || rbuf[b] !== exp_d[b] || rrsp[b] !== exp_r[b]) begin
        errors++; $display("FAIL top_beat%0d: to=%0d data=%h resp=%b, want %h %b", b, to, rbuf[b], rrsp[b], exp_d[b], exp_r[b]);
      end
    end
  endtask

  task automatic test_rready_toggle();
    logic [1:0] resp; logic [7:0] b_id; int lat, cyc, sb; bit to, fv, pa, pv;
    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    do_write(8'h07, BASE + 32'h100, 8'd7, 3'd3, INCR, 8'hFF, -1, resp, b_id, lat, to);
    checks++;
    if (to || resp !== OKAY) begin errors++; $display("FAIL toggle_write: to=%0d bresp=%b, want 0 00", to, resp); end
    do_read(8'h08, BASE + 32'h100, 8'd7, 3'd3, INCR, 1'b1, cyc, sb, fv, pa, pv, to);
    checks++;
    if (to || cyc !== 16 || sb !== 0) begin
      errors++; $display("FAIL toggle_timing: to=%0d cycles=%0d unstable=%0d, want 0 16 0", to, cyc, sb);
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rbuf[b] !== wbuf[b] || rrsp[b] !== OKAY || rlst[b] !== (b == 7)) begin
        errors++; $display("FAIL toggle_beat%0d: data=%h resp=%b last=%b, want %h 00 %0d", b, rbuf[b], rrsp[b], rlst[b], wbuf[b], (b == 7));
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp; logic [7:0] b_id; int lat, cyc, sb; bit to, to_r, fv, pa, pv;
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h55 + 64'(i);
    do_write(8'h09, BASE + 32'h200, 8'd3, 3'd3, INCR, 8'hFF, -1, resp, b_id, lat, to);
    for (int i = 0; i < 4; i++) wbuf[i] = 64'h66 + 64'(i);
    fork
      do_write(8'h5A, BASE + 32'h200, 8'd3, 3'd3, WRAP, 8'hFF, -1, resp, b_id, lat, to);
      do_read(8'h3C, BASE + 32'h100, 8'd3, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to_r);
    join
    checks++;
    if (to || resp !== SLVERR || b_id !== 8'h5A) begin
      errors++; $display("FAIL wrap_write: to=%0d bresp=%b bid=%h, want 0 10 5a", to, resp, b_id);
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (to_r || rrsp[b] !== OKAY || ridb[b] !== 8'h3C || rbuf[b] !== (64'hC0DE_0000_0000_0000 | 64'(b))) begin
        errors++; $display("FAIL concurrent_beat%0d: to=%0d resp=%b id=%h data=%h, want 00 3c c0de00000000000%0d",
                           b, to_r, rrsp[b], ridb[b], rbuf[b], b);
      end
    end
    do_read(8'h0A, BASE + 32'h200, 8'd3, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to_r);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (to_r || rbuf[b] !== 64'h55 + 64'(b)) begin
        errors++; $display("FAIL wrap_suppressed%0d: data=%h, want %h", b, rbuf[b], 64'h55 + 64'(b));
      end
    end
    do_write(8'hA7, BASE + 32'h300, 8'd3, 3'd3, INCR, 8'hFF, 1, resp, b_id, lat, to);
    checks++;
    if (to || resp !== SLVERR || b_id !== 8'hA7 || lat !== 0) begin
      errors++; $display("FAIL early_wlast: to=%0d bresp=%b bid=%h lat=%0d, want 0 10 a7 0", to, resp, b_id, lat);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] resp; logic [7:0] b_id; int lat, cyc, sb, n; bit to, fv, pa, pv;
    for (int i = 0; i < 16; i++) wbuf[i] = 64'h700 + 64'(i);
    awid = 8'h0B; awaddr = BASE + 32'h400; awlen = 8'd15; awsize = 3'd3; awburst = INCR; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    tick();
    awvalid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      wdata = wbuf[b]; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
      while (!wready && n < 100) begin tick(); n++; end
      tick();
    end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midrst_handshake: wait budget %0d exhausted", n); end
    rst = 1'b1; wvalid = 1'b0;
    tick();
    checks++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      errors++; $display("FAIL midrst_outputs: got %b, want 00000", {awready, wready, bvalid, arready, rvalid});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL midrst_awready: got %b, want 1", awready); end
    do_read(8'h0C, BASE + 32'h400, 8'd4, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to);
    for (int b = 0; b < 5; b++) begin
      checks++;
      if (to || rbuf[b] !== 64'h700 + 64'(b) || rrsp[b] !== OKAY) begin
        errors++; $display("FAIL midrst_partial%0d: data=%h resp=%b, want %h 00", b, rbuf[b], rrsp[b], 64'h700 + 64'(b));
      end
    end
    wbuf[0] = 64'hFEED_0001; wbuf[1] = 64'hFEED_0002;
    do_write(8'h0D, BASE + 32'h480, 8'd1, 3'd3, INCR, 8'hFF, -1, resp, b_id, lat, to);
    checks++;
    if (to || resp !== OKAY || b_id !== 8'h0D) begin
      errors++; $display("FAIL postrst_write: to=%0d bresp=%b bid=%h, want 0 00 0d", to, resp, b_id);
    end
    do_read(8'h0E, BASE + 32'h480, 8'd1, 3'd3, INCR, 1'b0, cyc, sb, fv, pa, pv, to);
    checks++;
    if (to || rbuf[0] !== 64'hFEED_0001 || rbuf[1] !== 64'hFEED_0002) begin
      errors++; $display("FAIL postrst_read: to=%0d data=%h %h, want feed0001 feed0002", to, rbuf[0], rbuf[1]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_narrow();
    test_top_of_mem();
    test_rready_toggle();
    test_errors();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
